axis_dllp_tlp_arbiter: RTL and testbench
========================================

AXIS_DLLP_TLP_ARBITER -- requirements
Module: axis_dllp_tlp_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, is the AXIS data width in bits.
REQ-002 Parameter KEEP_WIDTH, default DATA_WIDTH/8, is the tkeep width.
REQ-003 Parameter USER_WIDTH, default 2, is the output tuser width; bit1 = TLP, bit0 = DLLP; legal values are 2 or more.
REQ-004 Parameter MAX_DLLP_BURST, default 4, is the number of consecutive DLLP grants allowed while a TLP waits; legal range is 1..15.
REQ-005 clk_i  input  1  single clock; all state changes on the rising edge.
REQ-006 rst_i  input  1  reset, asynchronous and active-high.
REQ-007 link_active_i  input  1  data link is active; TLPs are eligible for grant only when this is 1.
REQ-008 s_tlp_axis_tdata/tkeep/tvalid/tlast/tready  in/in/in/in/out  DATA_WIDTH/KEEP_WIDTH/1/1/1  TLP source stream.
REQ-009 s_dllp_axis_tdata/tkeep/tvalid/tlast/tready  in/in/in/in/out  DATA_WIDTH/KEEP_WIDTH/1/1/1  DLLP source stream.
REQ-010 m_axis_tdata/tkeep/tvalid/tlast/tuser/tready  out/out/out/out/out/in  DATA_WIDTH/KEEP_WIDTH/1/1/USER_WIDTH/1  merged output stream.
REQ-011 busy_o  output  1  high while a packet is granted and not yet finished (state != ST_IDLE).

Function
REQ-012 The block SHALL arbitrate at packet granularity; once a packet is granted, no beat from the other source SHALL be interleaved until the granted packet's tlast beat is accepted.
REQ-013 The FSM SHALL have the states ST_IDLE, ST_DLLP and ST_TLP.
REQ-014 In ST_IDLE, the block SHALL pick a winner combinationally from the eligible requesters (tvalid=1; TLP also requires link_active_i=1).
REQ-015 Priority rule: DLLP wins, unless a TLP is eligible and dllp_streak == MAX_DLLP_BURST; in that case the TLP wins.
REQ-016 The winner's tready SHALL be asserted in the same cycle as the decision. If that first beat is accepted with tlast=1, the FSM SHALL stay in ST_IDLE. If it is accepted with tlast=0, the FSM SHALL go to ST_DLLP or ST_TLP. If it is not accepted, the FSM SHALL stay in ST_IDLE and re-arbitrate the next cycle.
REQ-017 In ST_DLLP or ST_TLP, only the granted source's tready SHALL be asserted. The FSM SHALL return to ST_IDLE on the accepted beat with tlast=1.
REQ-018 The non-granted source's tready SHALL be 0 at all times.
REQ-019 The output SHALL be a single register stage. It can accept a beat when m_axis_tvalid=0 or m_axis_tready=1. Granted tready SHALL equal that accept condition.
REQ-020 Latency SHALL be 1 cycle from input acceptance to m_axis_tvalid. Sustained throughput SHALL be 1 beat per cycle when m_axis_tready=1.
REQ-021 m_axis_tdata, tkeep and tlast SHALL be registered copies of the granted beat.
REQ-022 m_axis_tuser SHALL be registered as follows: bit1 = 1 for TLP beats, bit0 = 1 for DLLP beats, and any upper bits = 0.
REQ-023 Output data, keep, last and user SHALL hold stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-024 dllp_streak (4 bits) SHALL increment by 1 on each DLLP grant made while a TLP is eligible. It SHALL saturate at MAX_DLLP_BURST.
REQ-025 dllp_streak SHALL clear to 0 on every TLP grant, and SHALL also clear when no TLP is eligible in ST_IDLE.
REQ-026 If link_active_i falls during ST_TLP, the in-flight TLP SHALL complete normally, with no truncation. No new TLP SHALL be granted until link_active_i=1.
REQ-027 On simultaneous eligible requests with dllp_streak < MAX_DLLP_BURST, the DLLP SHALL win.

Reset
REQ-028 Asserting rst_i SHALL immediately force state=ST_IDLE, dllp_streak=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0, m_axis_tkeep=0, busy_o=0, and both s_*_tready=0.
REQ-029 A reset asserted mid-packet SHALL drop the remainder of the packet. After release, arbitration SHALL restart from ST_IDLE with no residual grant.

Verification
REQ-030 Single 3-beat TLP, link_active_i=1, m_axis_tready=1 -> 3 output beats starting 1 cycle after the first acceptance, tuser=2'b10, tlast only on beat 3, busy_o high between beats 1 and 3.
REQ-031 DLLP (2 beats) and TLP (4 beats) valid in the same cycle -> the DLLP is output first (tuser=2'b01), then the TLP, with no interleaving and no idle gap on the output.
REQ-032 MAX_DLLP_BURST=4; continuous back-to-back 2-beat DLLPs plus one pending TLP -> exactly 4 DLLPs are output, then the TLP, then DLLPs resume; dllp_streak reads 0 after the TLP grant.
REQ-033 TLP pending with link_active_i=0 and DLLPs streaming -> only DLLPs are output and s_tlp_axis_tready stays 0. Raise link_active_i -> the TLP is granted at the next ST_IDLE decision.
REQ-034 m_axis_tready held 0 for 5 cycles mid-TLP -> the output beat is stable and the source tready is 0. Release -> the remaining beats complete in order with no loss or duplication.
REQ-035 rst_i pulsed asynchronously mid-TLP (between clock edges) -> m_axis_tvalid and busy_o drop before the next edge. After release, a new DLLP is granted from ST_IDLE and output correctly.

Source files
------------

// File: rtl/axis_dllp_tlp_arbiter.sv
// Packet-granular arbiter that merges a DLLP and a TLP AXI-Stream source into one registered output.
// DLLPs normally win; a waiting TLP is forced through after MAX_DLLP_BURST consecutive DLLP grants.
module axis_dllp_tlp_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
  parameter int USER_WIDTH     = 2,
  parameter int MAX_DLLP_BURST = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  link_active_i,
  input  logic [DATA_WIDTH-1:0] s_tlp_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_tlp_axis_tkeep,
  input  logic                  s_tlp_axis_tvalid,
  input  logic                  s_tlp_axis_tlast,
  output logic                  s_tlp_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_dllp_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_dllp_axis_tkeep,
  input  logic                  s_dllp_axis_tvalid,
  input  logic                  s_dllp_axis_tlast,
  output logic                  s_dllp_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  input  logic                  m_axis_tready,
  output logic                  busy_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_DLLP, ST_TLP} state_t;

  localparam logic [3:0] MAX_STREAK = 4'(MAX_DLLP_BURST);

  state_t                  state, state_next;
  logic [3:0]              dllp_streak, streak_next;
  logic                    accept;
  logic                    dllp_elig, tlp_elig;
  logic                    sel_dllp, sel_tlp;
  logic                    take_dllp, take_tlp, take_last;
  logic [USER_WIDTH-1:0]   user_next;

  assign accept = !m_axis_tvalid || m_axis_tready;
  assign busy_o = (state != ST_IDLE);

  always_comb begin
    state_next  = state;
    streak_next = dllp_streak;
    sel_dllp    = 1'b0;
    sel_tlp     = 1'b0;
    dllp_elig   = s_dllp_axis_tvalid;
    tlp_elig    = s_tlp_axis_tvalid && link_active_i;

    case (state)
      ST_IDLE: begin
        if (tlp_elig && (!dllp_elig || dllp_streak == MAX_STREAK)) sel_tlp = 1'b1;
        else if (dllp_elig)                                         sel_dllp = 1'b1;
      end
      ST_DLLP: sel_dllp = 1'b1;
      ST_TLP:  sel_tlp  = 1'b1;
      default: ;
    endcase

    // Readies are gated by rst_i so both sources see tready=0 while reset is held.
    s_dllp_axis_tready = sel_dllp && accept && !rst_i;
    s_tlp_axis_tready  = sel_tlp && accept && !rst_i;
    take_dllp          = s_dllp_axis_tready && s_dllp_axis_tvalid;
    take_tlp           = s_tlp_axis_tready && s_tlp_axis_tvalid;
    take_last          = take_tlp ? s_tlp_axis_tlast : s_dllp_axis_tlast;

    if (take_dllp || take_tlp) begin
      if (take_last)     state_next = ST_IDLE;
      else if (take_tlp) state_next = ST_TLP;
      else               state_next = ST_DLLP;
    end

    if (state == ST_IDLE) begin
      if (!tlp_elig || take_tlp)                   streak_next = '0;
      else if (take_dllp && dllp_streak != MAX_STREAK) streak_next = dllp_streak + 4'd1;
    end

    user_next    = '0;
    user_next[1] = take_tlp;
    user_next[0] = take_dllp;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      dllp_streak <= '0;
    end else begin
      state       <= state_next;
      dllp_streak <= streak_next;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
    end else if (accept) begin
      m_axis_tvalid <= take_dllp || take_tlp;
      if (take_dllp || take_tlp) begin
        m_axis_tdata <= take_tlp ? s_tlp_axis_tdata : s_dllp_axis_tdata;
        m_axis_tkeep <= take_tlp ? s_tlp_axis_tkeep : s_dllp_axis_tkeep;
        m_axis_tlast <= take_last;
        m_axis_tuser <= user_next;
      end
    end
  end

endmodule

// File: tb/tb_axis_dllp_tlp_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic, scored against a rule-level
// arbitration model and per-source beat queues kept in the bench.
module tb_axis_dllp_tlp_arbiter;

  localparam int MAX_BURST = 4;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic [1:0]  user;
  } out_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        link;
  logic [31:0] t_data, d_data, m_data;
  logic [3:0]  t_keep, d_keep, m_keep;
  logic        t_valid, t_last, t_ready;
  logic        d_valid, d_last, d_ready;
  logic        m_valid, m_last, m_ready;
  logic [1:0]  m_user;
  logic        busy;

  beat_t      dq[$];
  beat_t      tq[$];
  out_t       oq[$];
  logic [1:0] plog[$];

  int checks = 0;
  int passes = 0;
  int owner  = 0;
  int streak = 0;
  bit mv     = 1'b0;
  int gap_pct = 0;
  int out_beats = 0;

  axis_dllp_tlp_arbiter #(
    .DATA_WIDTH    (32),
    .KEEP_WIDTH    (4),
    .USER_WIDTH    (2),
    .MAX_DLLP_BURST(MAX_BURST)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .link_active_i     (link),
    .s_tlp_axis_tdata  (t_data),
    .s_tlp_axis_tkeep  (t_keep),
    .s_tlp_axis_tvalid (t_valid),
    .s_tlp_axis_tlast  (t_last),
    .s_tlp_axis_tready (t_ready),
    .s_dllp_axis_tdata (d_data),
    .s_dllp_axis_tkeep (d_keep),
    .s_dllp_axis_tvalid(d_valid),
    .s_dllp_axis_tlast (d_last),
    .s_dllp_axis_tready(d_ready),
    .m_axis_tdata      (m_data),
    .m_axis_tkeep      (m_keep),
    .m_axis_tvalid     (m_valid),
    .m_axis_tlast      (m_last),
    .m_axis_tuser      (m_user),
    .m_axis_tready     (m_ready),
    .busy_o            (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_pkt(input bit is_tlp, input int nbeats);
    beat_t b;
    for (int i = 0; i < nbeats; i++) begin
      b.data = $urandom;
      b.keep = 4'($urandom_range(1, 15));
      b.last = (i == nbeats - 1);
      if (is_tlp) tq.push_back(b);
      else        dq.push_back(b);
    end
  endtask

  // Rule-level reference: who should be ready this cycle, and what the output register should hold.
  task automatic cycle_model();
    bit   accept, te, hsd, hst;
    int   win;
    out_t ob;
    ob = '{default: '0};
    accept = !mv || m_ready;
    te     = t_valid && link;
    if (owner == 0) win = (te && (!d_valid || streak == MAX_BURST)) ? 2 : (d_valid ? 1 : 0);
    else            win = owner;
    chk("dllp_tready", d_ready, (win == 1) && accept);
    chk("tlp_tready", t_ready, (win == 2) && accept);
    chk("busy", busy, owner != 0);
    chk("m_tvalid", m_valid, mv);
    if (mv && oq.size() > 0) begin
      chk("m_tdata", m_data, oq[0].data);
      chk("m_tkeep", m_keep, oq[0].keep);
      chk("m_tlast", m_last, oq[0].last);
      chk("m_tuser", m_user, oq[0].user);
    end
    if (m_valid && m_ready) begin
      out_beats++;
      if (m_last) plog.push_back(m_user);
    end
    if (mv && m_ready && oq.size() > 0) void'(oq.pop_front());
    hsd = (win == 1) && accept && d_valid;
    hst = (win == 2) && accept && t_valid;
    if (owner == 0) begin
      if (!te || hst)                     streak = 0;
      else if (hsd && streak < MAX_BURST) streak++;
    end
    if (hsd) begin
      ob = '{data: dq[0].data, keep: dq[0].keep, last: dq[0].last, user: 2'b01};
      owner = dq[0].last ? 0 : 1;
    end
    if (hst) begin
      ob = '{data: tq[0].data, keep: tq[0].keep, last: tq[0].last, user: 2'b10};
      owner = tq[0].last ? 0 : 2;
    end
    if (accept) begin
      mv = hsd || hst;
      if (mv) oq.push_back(ob);
    end
  endtask

  // Source drivers and per-cycle checking; inputs change 1 time unit after each rising edge.
  initial begin : driver
    bit hs_d, hs_t;
    d_valid = 1'b0; d_data = '0; d_keep = '0; d_last = 1'b0;
    t_valid = 1'b0; t_data = '0; t_keep = '0; t_last = 1'b0;
    forever begin
      @(negedge clk);
      hs_d = 1'b0;
      hs_t = 1'b0;
      if (!rst) begin
        cycle_model();
        hs_d = d_valid && d_ready;
        hs_t = t_valid && t_ready;
      end
      @(posedge clk);
      #1;
      if (rst) begin
        d_valid = 1'b0;
        t_valid = 1'b0;
      end else begin
        if (hs_d && dq.size() > 0) void'(dq.pop_front());
        if (hs_t && tq.size() > 0) void'(tq.pop_front());
        if (!d_valid || hs_d) begin
          d_valid = (dq.size() > 0) && ($urandom_range(0, 99) >= gap_pct);
          if (d_valid) begin d_data = dq[0].data; d_keep = dq[0].keep; d_last = dq[0].last; end
        end
        if (!t_valid || hs_t) begin
          t_valid = (tq.size() > 0) && ($urandom_range(0, 99) >= gap_pct);
          if (t_valid) begin t_data = tq[0].data; t_keep = tq[0].keep; t_last = tq[0].last; end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while ((dq.size() > 0 || tq.size() > 0 || oq.size() > 0) && n < max_cyc) begin
      tick();
      n++;
    end
    tick();
    tick();
    chk("drain_in_time", n < max_cyc, 1'b1);
  endtask

  task automatic wait_log(input int cnt, input int max_cyc);
    int n = 0;
    while (plog.size() < cnt && n < max_cyc) begin
      tick();
      n++;
    end
    chk("log_in_time", n < max_cyc, 1'b1);
  endtask

  task automatic check_log(input string s);
    logic [1:0] e;
    chk("pkt_count", plog.size(), s.len());
    for (int i = 0; i < s.len() && i < plog.size(); i++) begin
      e = (s.getc(i) == "T") ? 2'b10 : 2'b01;
      chk("pkt_src", plog[i], e);
    end
  endtask

  initial begin : stimulus
    int n;
    rst = 1'b1;
    link = 1'b1;
    m_ready = 1'b1;
    #12;
    chk("rst_m_tvalid", m_valid, 1'b0);
    chk("rst_m_tdata", m_data, 32'h0);
    chk("rst_m_tuser", m_user, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_treadys", {d_ready, t_ready}, 2'b00);
    @(posedge clk);
    #3 rst = 1'b0;

    // Single 3-beat TLP
    plog.delete();
    push_pkt(1'b1, 3);
    drain(50);
    check_log("T");

    // Simultaneous DLLP and TLP: DLLP first, no interleave
    plog.delete();
    push_pkt(1'b0, 2);
    push_pkt(1'b1, 4);
    drain(50);
    check_log("DT");

    // DLLP burst limit with a pending TLP
    plog.delete();
    push_pkt(1'b1, 2);
    for (int i = 0; i < 6; i++) push_pkt(1'b0, 2);
    drain(100);
    check_log("DDDDTDD");

    // TLP held off while link is down
    plog.delete();
    link = 1'b0;
    push_pkt(1'b1, 2);
    for (int i = 0; i < 3; i++) push_pkt(1'b0, 2);
    wait_log(3, 100);
    tick();
    tick();
    check_log("DDD");
    chk("tlp_held", tq.size(), 2);
    link = 1'b1;
    drain(50);
    check_log("DDDT");

    // Output stall mid-TLP
    plog.delete();
    out_beats = 0;
    push_pkt(1'b1, 4);
    n = 0;
    while (out_beats < 1 && n < 50) begin tick(); n++; end
    chk("first_beat_in_time", n < 50, 1'b1);
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_tlp_tready", t_ready, 1'b0);
    end
    m_ready = 1'b1;
    drain(50);
    check_log("T");
    chk("stall_beats", out_beats, 4);

    // Asynchronous reset mid-TLP, then a fresh DLLP
    plog.delete();
    push_pkt(1'b1, 4);
    n = 0;
    while (owner != 2 && n < 50) begin tick(); n++; end
    chk("tlp_granted_in_time", n < 50, 1'b1);
    tick();
    #1 rst = 1'b1;
    #1;
    chk("arst_m_tvalid", m_valid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_treadys", {d_ready, t_ready}, 2'b00);
    chk("arst_m_tdata", m_data, 32'h0);
    dq.delete();
    tq.delete();
    oq.delete();
    owner = 0;
    streak = 0;
    mv = 1'b0;
    @(posedge clk);
    #3 rst = 1'b0;
    plog.delete();
    push_pkt(1'b0, 2);
    drain(50);
    check_log("D");

    // Randomized traffic with backpressure, link toggling and source gaps
    gap_pct = 25;
    for (int c = 0; c < 600; c++) begin
      tick();
      m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) link = ~link;
      if (dq.size() < 8 && $urandom_range(0, 2) == 0) push_pkt(1'b0, int'($urandom_range(1, 4)));
      if (tq.size() < 8 && $urandom_range(0, 3) == 0) push_pkt(1'b1, int'($urandom_range(1, 4)));
    end
    m_ready = 1'b1;
    link = 1'b1;
    gap_pct = 0;
    drain(1000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
